// File: rtl/spi_flash_reader.sv
// spi_flash_reader: single-lane SPI (mode 0) master that issues a 0x03 READ
// and returns the requested bytes on a valid/ready stream.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request, flash_csb high
// CMD   | shifting out the 0x03 opcode, MSB first
// ADDR  | shifting out the 24-bit byte address, MSB first
// DATA  | clocking in one byte on flash_io1, flash_io0 held low
// HOLD  | byte presented on rd_*, flash_clk parked low until handshake
// DESEL | flash_csb high for CSB_HIGH cycles before the next request
module spi_flash_reader #(
    parameter int CLK_DIV  = 2,
    parameter int CSB_HIGH = 4
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, DESEL} state_t;

    localparam int            TW         = 16;
    localparam logic [TW-1:0] DIV_LOAD   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] DESEL_LOAD = TW'(CSB_HIGH - 1);

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [4:0]    bit_cnt;
    logic [7:0]    byte_cnt;
    logic [31:0]   tx_shift;
    logic [7:0]    rx_shift;
    logic          sck;
    logic          csb_q;

    logic shifting;
    logic tick;
    logic sck_rise;
    logic sck_fall;
    logic last_bit;

    // SCK phase boundaries: timer terminal count toggles the clock; a rising
    // toggle samples MISO, a falling toggle advances MOSI.
    assign shifting = (state == CMD) || (state == ADDR) || (state == DATA);
    assign tick     = (timer == '0);
    assign sck_rise = shifting && tick && !sck;
    assign sck_fall = shifting && tick && sck;
    assign last_bit = (bit_cnt == 5'd0);

    assign flash_csb = csb_q;
    assign flash_clk = sck;
    assign flash_io0 = tx_shift[31];
    assign rd_data   = rx_shift;

    // State register
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_next = CMD;
            end
            CMD:   if (sck_fall && last_bit) state_next = ADDR;
            ADDR:  if (sck_fall && last_bit) state_next = DATA;
            DATA:  if (sck_fall && last_bit) state_next = HOLD;
            HOLD: begin
                rd_valid = 1'b1;
                rd_last  = (byte_cnt == 8'd0);
                if (rd_ready) state_next = (byte_cnt == 8'd0) ? DESEL : DATA;
            end
            DESEL: if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: SCK divider, shift registers, byte and bit counters, chip select
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            timer    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            sck      <= 1'b0;
            csb_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tx_shift <= {8'h03, req_addr};
                        byte_cnt <= req_len;
                        bit_cnt  <= 5'd7;
                        timer    <= DIV_LOAD;
                        sck      <= 1'b0;
                        csb_q    <= 1'b0;
                    end
                end
                CMD, ADDR, DATA: begin
                    if (tick) begin
                        timer <= DIV_LOAD;
                        sck   <= ~sck;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                    if (sck_rise && (state == DATA)) begin
                        rx_shift <= {rx_shift[6:0], flash_io1};
                    end
                    if (sck_fall) begin
                        tx_shift <= {tx_shift[30:0], 1'b0};
                        if (last_bit) begin
                            bit_cnt <= (state == CMD) ? 5'd23 : 5'd7;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (rd_ready) begin
                        if (byte_cnt == 8'd0) begin
                            csb_q <= 1'b1;
                            timer <= DESEL_LOAD;
                        end else begin
                            byte_cnt <= byte_cnt - 8'd1;
                            timer    <= DIV_LOAD;
                        end
                    end
                end
                DESEL: begin
                    if (!tick) timer <= timer - TW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
